// File: rtl/mips_mem_pkg.sv
// Shared constants and encodings for the MIPS memory/IO subsystem.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_mem_pkg;

  // Default port addresses; the shared 0xFFFC slot is inport1 on reads and out_port on writes.
  localparam logic [31:0] INPORT0_ADDR_DEF = 32'h0000_FFF8;
  localparam logic [31:0] INPORT1_ADDR_DEF = 32'h0000_FFFC;
  localparam logic [31:0] OUTPORT_ADDR_DEF = 32'h0000_FFFC;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_PEND = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_RAM  = 2'd0,
    SEL_IN0  = 2'd1,
    SEL_IN1  = 2'd2,
    SEL_NONE = 2'd3
  } sel_t;

  // Read-side decode. RAM wins over the ports; ports match on all 32 bits.
  function automatic sel_t rd_decode(input logic [31:0] a,
                                     input logic [31:0] ram_bytes,
                                     input logic [31:0] in0_addr,
                                     input logic [31:0] in1_addr);
    if (a < ram_bytes)      return SEL_RAM;
    else if (a == in0_addr) return SEL_IN0;
    else if (a == in1_addr) return SEL_IN1;
    else                    return SEL_NONE;
  endfunction

endpackage

// File: rtl/mips_mem_io_if.sv
// Memory request/response bus between the multicycle MIPS controller and mips_mem_io.
// Latency: reads answer one edge after acceptance; writes commit at the request edge.
// Backpressure: none; busy only signals that a read is in flight and new requests are dropped.
interface mips_mem_io_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;

  modport master (
    output mem_read, mem_write, addr, wr_data,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  mem_read, mem_write, addr, wr_data,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/mips_ram_sp.sv
// Single-port synchronous word RAM, WORDS x 32, no reset of contents.
// Latency: registered read, data valid one edge after i_en; write commits at the i_en edge.
// Backpressure: none; read-during-write returns the old word.
module mips_ram_sp #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  // Read-first port: the output register always captures the pre-write contents.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_mem_io.sv
// Word RAM plus two latched input ports and one output port behind the MIPS memory bus.
// Latency: read data and rd_valid one edge after the accepting edge; writes commit at the request edge.
// Backpressure: none; requests arriving while a read is pending are dropped (flagged on err).
// Optional: define MIPS_MEMIO_ERR_EN for sticky err on misaligned, colliding or dropped requests.
module mips_mem_io
  import mips_mem_pkg::*;
#(
  parameter int          RAM_WORDS    = 256,
  parameter logic [31:0] INPORT0_ADDR = INPORT0_ADDR_DEF,
  parameter logic [31:0] INPORT1_ADDR = INPORT1_ADDR_DEF,
  parameter logic [31:0] OUTPORT_ADDR = OUTPORT_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_mem_io_if.slave         mem,
  input  logic [31:0]          in_data,
  input  logic                 in0_en,
  input  logic                 in1_en,
  output logic [31:0]          out_port,
  output logic                 out_strobe,
  output logic                 err
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

  state_t      r_state;
  sel_t        r_sel;
  logic [31:0] r_port_q;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_busy;
  logic [31:0] r_out_port;
  logic        r_out_strobe;
  logic        r_err;
  logic [31:0] r_in0;
  logic [31:0] r_in1;

  logic [31:0] w_addr_eff;
  logic        w_misalign;
  logic        w_err_evt;
  logic        w_idle;
  logic        w_rd_req;
  logic        w_wr_req;
  logic        w_in_ram;
  logic        w_wr_out;
  sel_t        w_rd_sel;
  logic [31:0] w_ram_rdata;

`ifdef MIPS_MEMIO_ERR_EN
  assign w_addr_eff = mem.addr;
  assign w_misalign = |mem.addr[1:0];
  // Any request that is dropped or partially honoured raises the sticky flag.
  assign w_err_evt  = (mem.mem_read | mem.mem_write) &
                      ((r_state == RD_PEND) | w_misalign | (mem.mem_read & mem.mem_write));
`else
  // Without error checking the byte offset is simply discarded.
  assign w_addr_eff = mem.addr & 32'hFFFF_FFFC;
  assign w_misalign = 1'b0;
  assign w_err_evt  = 1'b0;
`endif

  assign w_idle   = (r_state == IDLE);
  // A simultaneous read+write is treated as a write; the read half is lost.
  assign w_rd_req = w_idle & mem.mem_read & ~mem.mem_write & ~w_misalign;
  assign w_wr_req = w_idle & mem.mem_write & ~w_misalign;
  assign w_in_ram = (w_addr_eff < RAM_BYTES);
  assign w_wr_out = w_wr_req & (w_addr_eff == OUTPORT_ADDR);
  assign w_rd_sel = rd_decode(w_addr_eff, RAM_BYTES, INPORT0_ADDR, INPORT1_ADDR);

  mips_ram_sp #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_rd_req | (w_wr_req & w_in_ram)),
    .i_we    (w_wr_req & w_in_ram),
    .i_addr  (w_addr_eff[2 +: AW]),
    .i_wdata (mem.wr_data),
    .o_rdata (w_ram_rdata)
  );

  // Input port latches run every edge regardless of bus activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in0 <= '0;
      r_in1 <= '0;
    end else begin
      if (in0_en) r_in0 <= in_data;
      if (in1_en) r_in1 <= in_data;
    end
  end

  // Bus FSM: accepts reads/writes in IDLE, returns read data from RD_PEND, tracks err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sel        <= SEL_NONE;
      r_port_q     <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_out_port   <= '0;
      r_out_strobe <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rd_valid   <= 1'b0;
      r_out_strobe <= 1'b0;
      r_err        <= r_err | w_err_evt;
      case (r_state)
        IDLE: begin
          if (w_rd_req) begin
            // Port value is sampled at the accepting edge, so a same-edge latch is not seen.
            r_sel    <= w_rd_sel;
            r_port_q <= (w_rd_sel == SEL_IN0) ? r_in0 : r_in1;
            r_busy   <= 1'b1;
            r_state  <= RD_PEND;
          end
          if (w_wr_out) begin
            r_out_port   <= mem.wr_data;
            r_out_strobe <= 1'b1;
          end
        end
        RD_PEND: begin
          case (r_sel)
            SEL_RAM:          r_rd_data <= w_ram_rdata;
            SEL_IN0, SEL_IN1: r_rd_data <= r_port_q;
            default:          r_rd_data <= '0;
          endcase
          r_rd_valid <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem.rd_data  = r_rd_data;
  assign mem.rd_valid = r_rd_valid;
  assign mem.busy     = r_busy;
  assign out_port     = r_out_port;
  assign out_strobe   = r_out_strobe;
  assign err          = r_err;

endmodule

// File: tb/tb_mips_mem_io.sv
// Directed bench for mips_mem_io: RAM, ports, collisions, reset abort and unmapped access.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Expectations for err and misaligned access follow MIPS_MEMIO_ERR_EN.
module tb_mips_mem_io;

`ifdef MIPS_MEMIO_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in0_en;
  logic        in1_en;
  logic [31:0] out_port;
  logic        out_strobe;
  logic        err;
  int          n_checks;
  int          n_fail;

  mips_mem_io_if bus ();

  mips_mem_io dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (bus),
    .in_data    (in_data),
    .in0_en     (in0_en),
    .in1_en     (in1_en),
    .out_port   (out_port),
    .out_strobe (out_strobe),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_write = 1'b1;
    bus.addr      = a;
    bus.wr_data   = d;
    tick();
    bus.mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus.mem_read = 1'b1;
    bus.addr     = a;
    tick();
    bus.mem_read = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_vld_early"}, 32'(bus.rd_valid), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(bus.rd_valid), 32'd1);
    chk({tag, "_data"}, bus.rd_data, exp);
    chk({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
    tick();
    chk({tag, "_vld_clr"}, 32'(bus.rd_valid), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.wr_data   = '0;
    in_data       = '0;
    in0_en        = 1'b0;
    in1_en        = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_port", out_port, 32'd0);
    chk("rst_out_strobe", 32'(out_strobe), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // RAM write then read back
    wr(32'h10, 32'hDEAD_BEEF);
    chk("wr_busy", 32'(bus.busy), 32'd0);
    chk("wr_ram_no_strobe", 32'(out_strobe), 32'd0);
    rd(32'h10, 32'hDEAD_BEEF, "ram10");
    chk("ram10_hold", bus.rd_data, 32'hDEAD_BEEF);

    // Input port 0 latch, port 1 still at reset value
    in_data = 32'hA5;
    in0_en  = 1'b1;
    tick();
    in0_en = 1'b0;
    rd(32'hFFF8, 32'hA5, "in0");
    rd(32'hFFFC, 32'h0, "in1_rst");

    // Latch and read of inport1 at the same edge returns the old value
    in_data      = 32'h77;
    in1_en       = 1'b1;
    bus.mem_read = 1'b1;
    bus.addr     = 32'hFFFC;
    tick();
    in1_en       = 1'b0;
    bus.mem_read = 1'b0;
    tick();
    chk("same_edge_vld", 32'(bus.rd_valid), 32'd1);
    chk("same_edge_data", bus.rd_data, 32'h0);
    tick();
    rd(32'hFFFC, 32'h77, "in1_new");

    // Both enables latch the same value
    in_data = 32'h3C;
    in0_en  = 1'b1;
    in1_en  = 1'b1;
    tick();
    in0_en = 1'b0;
    in1_en = 1'b0;
    rd(32'hFFF8, 32'h3C, "both_in0");
    rd(32'hFFFC, 32'h3C, "both_in1");

    // Output port write on the shared address; inport1 untouched
    wr(32'hFFFC, 32'h1234);
    chk("outp_val", out_port, 32'h1234);
    chk("outp_strobe", 32'(out_strobe), 32'd1);
    tick();
    chk("outp_strobe_clr", 32'(out_strobe), 32'd0);
    rd(32'hFFFC, 32'h3C, "in1_after_out");

    // Simultaneous read and write: write only
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    bus.addr      = 32'h20;
    bus.wr_data   = 32'h55;
    tick();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    chk("rw_busy", 32'(bus.busy), 32'd0);
    chk("rw_err", 32'(err), 32'(ERR_ON));
    tick();
    chk("rw_no_vld", 32'(bus.rd_valid), 32'd0);
    rd(32'h20, 32'h55, "rw_ram8");

    // Second request while a read is pending is dropped
    wr(32'h04, 32'hCAFE_0004);
    bus.mem_read = 1'b1;
    bus.addr     = 32'h04;
    tick();
    chk("pend_busy", 32'(bus.busy), 32'd1);
    bus.addr = 32'h10;
    tick();
    bus.mem_read = 1'b0;
    chk("pend_vld", 32'(bus.rd_valid), 32'd1);
    chk("pend_data", bus.rd_data, 32'hCAFE_0004);
    chk("pend_err", 32'(err), 32'(ERR_ON));
    tick();
    chk("pend_vld_clr", 32'(bus.rd_valid), 32'd0);
    chk("pend_busy_clr", 32'(bus.busy), 32'd0);
    tick();
    chk("pend_no_second", 32'(bus.rd_valid), 32'd0);

    // Reset while a read is pending
    bus.mem_read = 1'b1;
    bus.addr     = 32'h10;
    tick();
    bus.mem_read = 1'b0;
    rst          = 1'b1;
    chk("abort_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("abort_vld", 32'(bus.rd_valid), 32'd0);
    chk("abort_data", bus.rd_data, 32'd0);
    chk("abort_busy_clr", 32'(bus.busy), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_out_port", out_port, 32'd0);
    chk("abort_strobe", 32'(out_strobe), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_no_late_vld", 32'(bus.rd_valid), 32'd0);
    rd(32'h20, 32'h55, "ram_kept");
    rd(32'hFFFC, 32'h0, "in1_cleared");

    // Unmapped read returns zero, err unchanged
    rd(32'h10, 32'hDEAD_BEEF, "pre_unmapped");
    rd(32'h0001_0000, 32'h0, "unmapped");
    chk("unmapped_err", 32'(err), 32'd0);

    // Misaligned read
    bus.mem_read = 1'b1;
    bus.addr     = 32'h11;
    tick();
    bus.mem_read = 1'b0;
    chk("mis_busy", 32'(bus.busy), ERR_ON ? 32'd0 : 32'd1);
    tick();
    chk("mis_vld", 32'(bus.rd_valid), ERR_ON ? 32'd0 : 32'd1);
    chk("mis_data", bus.rd_data, ERR_ON ? 32'h0 : 32'hDEAD_BEEF);
    chk("mis_err", 32'(err), 32'(ERR_ON));
    tick();

    // Unmapped write is dropped
    wr(32'h0001_0000, 32'hFFFF);
    chk("unm_wr_strobe", 32'(out_strobe), 32'd0);
    chk("unm_wr_out_port", out_port, 32'd0);
    chk("unm_wr_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
